// File: rtl/pwconv_pkg.sv
// Shared constants, FSM state encoding and result-tag type for the
// pointwise-convolution point sequencer.
package pwconv_pkg;

    localparam int unsigned CH_IN     = 32;
    localparam int unsigned LANE_W    = 32;
    localparam int unsigned VEC_W     = 256;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned TAG_IDX_W = 16;

    typedef logic [TAG_IDX_W-1:0] tag_idx_t;

    typedef struct packed {
        logic     valid;
        tag_idx_t pix;
        tag_idx_t oc;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/pwconv_point_sequencer_if.sv
// Tagged result stream from the sequencer to downstream requantization.
interface pwconv_point_sequencer_if #(
    parameter int unsigned PIX_W = 6,
    parameter int unsigned OC_W  = 5
);

    logic                                   res_valid;
    logic                                   res_ready;
    logic signed [pwconv_pkg::ACC_W-1:0]    res_data;
    logic [PIX_W-1:0]                       res_pix;
    logic [OC_W-1:0]                        res_oc;

    modport master (
        output res_valid, res_data, res_pix, res_oc,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_data, res_pix, res_oc,
        output res_ready
    );

endinterface

// File: rtl/pwconv_tag_pipe.sv
// Enable-gated shift register of result tags; tracks items in flight
// through the point unit so results can be labelled at its output.
module pwconv_tag_pipe
    import pwconv_pkg::*;
#(
    parameter int unsigned DEPTH = 5
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_en,
    input  tag_t i_tag,
    output tag_t o_head,
    output tag_t o_tail,
    output logic o_any_valid
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_any_valid = o_any_valid | r_stage[i].valid;
        end
    end

    assign o_head = r_stage[0];
    assign o_tail = r_stage[DEPTH-1];

endmodule

// File: rtl/pwconv_point_sequencer.sv
// Front-end driver for the 32-channel pointwise-convolution point unit:
// walks (pixel, out-channel), fetches operands and tags every result.
module pwconv_point_sequencer
    import pwconv_pkg::*;
#(
    parameter int unsigned NUM_PIX  = 64,
    parameter int unsigned OUT_CH   = 32,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned PIX_W    = $clog2(NUM_PIX),
    parameter int unsigned OC_W     = $clog2(OUT_CH)
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fm_rd_en,
    output logic [PIX_W-1:0]        fm_addr,
    input  logic [0:VEC_W-1]        fm_rdata,
    output logic                    w_rd_en,
    output logic [OC_W-1:0]         w_addr,
    input  logic [0:VEC_W-1]        w_rdata,
    input  logic signed [ACC_W-1:0] b_rdata,
    output logic                    conv_en,
    output logic [0:VEC_W-1]        conv_data_in,
    output logic [0:VEC_W-1]        conv_weight,
    output logic signed [ACC_W-1:0] conv_bias,
    input  logic signed [ACC_W-1:0] conv_data_out,
    pwconv_point_sequencer_if.master res
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
    localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUT_CH - 1);

    state_t           r_state;
    logic [PIX_W-1:0] r_pix;
    logic [OC_W-1:0]  r_oc;
    logic [0:VEC_W-1] r_fm_hold;

    tag_t w_iss_tag;
    tag_t w_head;
    tag_t w_tail;
    logic w_any_valid;
    logic w_stall;
    logic w_en;
    logic w_issue;
    logic w_head_first;
    logic w_unused;

    // A stalled output freezes the whole pipe, so no SRAM read may fire then.
    assign w_stall = w_tail.valid & ~res.res_ready;
    assign busy    = (r_state != S_IDLE);
    assign w_en    = busy & ~w_stall;
    assign w_issue = (r_state == S_ISSUE) & ~w_stall;
    assign done    = (r_state == S_DRAIN) & ~w_any_valid;
    assign conv_en = w_en;

    assign w_rd_en  = w_issue;
    assign w_addr   = r_oc;
    assign fm_rd_en = w_issue & (r_oc == '0);
    assign fm_addr  = r_pix;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_pix   <= '0;
            r_oc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_pix   <= '0;
                        r_oc    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        if (r_oc == OC_LAST) begin
                            r_oc <= '0;
                            if (r_pix == PIX_LAST) begin
                                r_pix   <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_pix <= r_pix + 1'b1;
                            end
                        end else begin
                            r_oc <= r_oc + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_any_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_iss_tag       = '0;
        w_iss_tag.valid = (r_state == S_ISSUE);
        w_iss_tag.pix   = tag_idx_t'(r_pix);
        w_iss_tag.oc    = tag_idx_t'(r_oc);
    end

    pwconv_tag_pipe #(
        .DEPTH (PIPE_LAT + 1)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_b       (rst_b),
        .i_en        (w_en),
        .i_tag       (w_iss_tag),
        .o_head      (w_head),
        .o_tail      (w_tail),
        .o_any_valid (w_any_valid)
    );

    // Feature vector is fetched once per pixel; later channels reuse this copy.
    assign w_head_first = w_head.valid & (w_head.oc == '0);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_fm_hold <= '0;
        end else if (w_en && w_head_first) begin
            r_fm_hold <= fm_rdata;
        end
    end

    assign conv_data_in = !w_head.valid ? '0 : (w_head_first ? fm_rdata : r_fm_hold);
    assign conv_weight  = w_head.valid ? w_rdata : '0;
    assign conv_bias    = w_head.valid ? b_rdata : '0;

    assign res.res_valid = w_tail.valid;
    assign res.res_data  = w_tail.valid ? conv_data_out : '0;
    assign res.res_pix   = PIX_W'(w_tail.pix);
    assign res.res_oc    = OC_W'(w_tail.oc);

    assign w_unused = ^{w_head.pix, w_tail.pix, w_tail.oc};

endmodule

// File: doc/pwconv_point_sequencer.md
Name: pwconv_point_sequencer

Overview:
- Front-end driver for the 32-input-channel pointwise convolution point unit (8 MultAdd4 lanes + Add9; int8 operands, 32-bit signed result).
- For every pixel and output channel, fetches the packed 32-channel int8 feature vector, the 256-bit weight vector and the 32-bit bias. Presents them to the point unit and drives its global enable.
- Tags and returns each 32-bit result over a valid/ready stream to downstream requantization.
- Sits between feature/weight SRAMs and the point unit in the PWconv_1_1_32 layer.

Parameters:
- NUM_PIX, 64, pixels per layer invocation; feature SRAM depth.
- OUT_CH, 32, output channels; weight/bias memory depth.
- PIPE_LAT, 4, enabled-cycle latency of the point unit from operand presentation to data_out.
- PIX_W, $clog2(NUM_PIX), pixel index width.
- OC_W, $clog2(OUT_CH), output-channel index width.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a layer pass.
- busy  out  1  high from the cycle after accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse when the last result is accepted.
- fm_rd_en  out  1  feature SRAM read enable.
- fm_addr  out  PIX_W  pixel address.
- fm_rdata  in  [0:255]  32 int8 channels, channel 0 in bits [0:7]; valid 1 cycle after fm_rd_en; held while fm_rd_en is low.
- w_rd_en  out  1  weight/bias read enable.
- w_addr  out  OC_W  output-channel address.
- w_rdata  in  [0:255]  weight vector, same packing as fm_rdata.
- b_rdata  in  signed 32  bias; same timing as w_rdata.
- conv_en  out  1  global enable to the point unit.
- conv_data_in  out  [0:255]  to point unit data_in.
- conv_weight  out  [0:255]  to point unit weight.
- conv_bias  out  signed 32  to point unit bias.
- conv_data_out  in  signed 32  from point unit.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream ready.
- res_data  out  signed 32  result.
- res_pix  out  PIX_W  pixel tag.
- res_oc  out  OC_W  output-channel tag.

Behaviour:
- Reset (rst_b=0 at a clk edge): all outputs 0, counters 0, tag pipeline cleared, FSM=IDLE. Reset mid-pass abandons the pass; no done. The point unit shares rst_b.
- FSM states and transitions:
  - IDLE: start=1 -> ISSUE.
  - ISSUE: generates one (pix,oc) per non-stalled cycle, oc inner loop, pix outer loop. After issuing (NUM_PIX-1, OUT_CH-1) -> DRAIN.
  - DRAIN: no new issues; stays until the tag pipeline is empty and the last result is accepted, then -> IDLE with done=1 for that cycle.
  - start is ignored when not in IDLE.
- stall = res_valid & ~res_ready. conv_en = busy & ~stall. A stall freezes every stage: address counters, operand stage, tag shift register and the point unit.
- Issue stage (cycle t, not stalled):
  - w_rd_en=1, w_addr=oc.
  - fm_rd_en=1 only when oc==0, with fm_addr=pix. The feature vector is read once per pixel.
- Operand stage (cycle t+1):
  - conv_weight=w_rdata and conv_bias=b_rdata.
  - conv_data_in = fm_rdata when the item has oc==0; otherwise the registered copy captured at oc==0.
  - Operands stay stable across stalls. SRAM outputs hold because no read is issued while stalled.
- Tag pipeline: PIPE_LAT+1 stages of {valid,pix,oc} advance only when conv_en=1. The stage at the output drives res_valid/res_pix/res_oc. res_data = conv_data_out.
- Throughput: 1 result/cycle with res_ready held high. Latency from start to first res_valid = PIPE_LAT+2 cycles. Total cycles = NUM_PIX*OUT_CH + PIPE_LAT + 2 + stall cycles.
- res_data/res_pix/res_oc are held while res_valid & ~res_ready.
- Bubbles carry valid=0 and never produce res_valid.
- Counters wrap: oc OUT_CH-1->0 increments pix. pix does not wrap past NUM_PIX-1 within a pass.
- A start pulse in the same cycle as done is ignored. A new pass requires start in IDLE.

Decomposition:
- Shared package pwconv_pkg:
  - Constants: CH_IN=32, LANE_W=32, VEC_W=256, ACC_W=32.
  - Typedef of the tag struct {valid, pix, oc}.
- One sub-module: pwconv_tag_pipe, an enable-gated parameterised-depth shift register of tags.

Test Plan:
- NUM_PIX=2, OUT_CH=2, all-ones features, weights=1, bias 0/5, res_ready=1 -> results 32,37,32,37 with tags (0,0),(0,1),(1,0),(1,1). First res_valid 6 cycles after start; done 1 cycle after the 4th accept.
- Random int8 features/weights/biases, full default config, random res_ready -> 2048 results match golden sum(f*w)+b in order. No duplicates, no drops, tags monotonic.
- res_ready=0 for 10 cycles mid-stream -> conv_en=0 and res_* stable for all 10 cycles. fm_rd_en=w_rd_en=0 throughout. Stream resumes without loss.
- Feature reads: count fm_rd_en pulses over a full pass -> exactly NUM_PIX (64). w_rd_en pulses = 2048.
- rst_b=0 for 1 cycle at result 100 -> next cycle all outputs 0, busy=0, no done. A new start produces a full correct pass.
- start pulsed while busy, and again on the done cycle -> both ignored. Exactly one pass runs.
